// File: rtl/spi_regmap_ctrl.sv
// SPI register-map controller: command decode, turnaround status and burst access to N_REGS bytes.
// Define REGMAP_AUTOINC_EN for address auto-increment with wrap at N_REGS-1 -> 0.
module spi_regmap_ctrl #(
  parameter int                  N_REGS       = 8,
  parameter logic [N_REGS-1:0]   RO_MASK      = '0,
  parameter logic [N_REGS*8-1:0] RESET_VALUES = '0,
  parameter logic [7:0]          ACK_BYTE     = 8'hFF
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  spi_cs_active,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  output logic [7:0]            tx_byte,
  output logic [N_REGS*8-1:0]   cfg_out,
  output logic [N_REGS-1:0]     wr_stb,
  input  logic [N_REGS*8-1:0]   ro_data,
  output logic                  xfer_err,
  output logic                  busy
);
  localparam logic [6:0] LOW_MASK = 7'(N_REGS - 1);
  localparam logic [7:0] N_REGS_B = 8'(N_REGS);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_TURN, S_DATA} state_t;

  state_t                   r_state, w_state_nxt;
  logic                     r_cs_d;
  logic                     r_rw;
  logic [6:0]               r_addr;
  logic [7:0]               r_regs [N_REGS];
  logic [7:0]               r_tx;
  logic [N_REGS-1:0]        r_wr_stb;
  logic                     r_err;

  logic                     w_act;
  logic                     w_cmd_ok;
  logic                     w_addr_ok;
  logic [6:0]               w_addr_inc;
  logic [6:0]               w_addr_adv;
  logic [7:0]               w_rd_val [N_REGS];
  logic [7:0]               w_rd_cur;
  logic [7:0]               w_rd_adv;
  logic [N_REGS-1:0]        w_hit;
  logic [N_REGS-1:0]        w_wr_ok;
  logic [7:0]               w_tx_nxt;
  logic [N_REGS-1:0]        w_wr_nxt;
  logic                     w_err_nxt;

  assign w_act     = spi_cs_active & rx_valid;
  assign w_cmd_ok  = {1'b0, rx_byte[6:0]} < N_REGS_B;
  assign w_addr_ok = {1'b0, r_addr} < N_REGS_B;
  // Only the low AW bits count up, so valid bursts wrap and invalid ones stay invalid.
  assign w_addr_inc = (r_addr & ~LOW_MASK) | ((r_addr + 7'd1) & LOW_MASK);
`ifdef REGMAP_AUTOINC_EN
  assign w_addr_adv = w_addr_inc;
`else
  assign w_addr_adv = r_addr;
`endif

  always_comb begin
    w_rd_cur = 8'h00;
    w_rd_adv = 8'h00;
    w_hit    = '0;
    for (int i = 0; i < N_REGS; i++) begin
      w_rd_val[i] = RO_MASK[i] ? ro_data[i*8 +: 8] : r_regs[i];
      w_hit[i]    = (r_addr == 7'(i));
      if (r_addr == 7'(i))     w_rd_cur = w_rd_val[i];
      if (w_addr_adv == 7'(i)) w_rd_adv = w_rd_val[i];
    end
  end

  assign w_wr_ok = w_hit & ~RO_MASK;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_cs_d  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cs_d  <= spi_cs_active;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!spi_cs_active) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (!r_cs_d)  w_state_nxt = S_CMD;
        S_CMD:   if (rx_valid) w_state_nxt = S_TURN;
        S_TURN:  if (rx_valid) w_state_nxt = S_DATA;
        S_DATA:                w_state_nxt = S_DATA;
        default:               w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_tx_nxt  = r_tx;
    w_wr_nxt  = '0;
    w_err_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: if (spi_cs_active && !r_cs_d) w_tx_nxt = ACK_BYTE;
      S_CMD:  if (w_act) w_tx_nxt = {7'b0, w_cmd_ok};
      S_TURN: if (w_act && !r_rw) w_tx_nxt = w_rd_cur;
      S_DATA: begin
        if (w_act) begin
          if (r_rw) begin
            w_wr_nxt  = w_wr_ok;
            w_err_nxt = ~(|w_wr_ok);
          end else begin
            w_tx_nxt  = w_rd_adv;
            w_err_nxt = ~w_addr_ok;
          end
        end
      end
      default: w_tx_nxt = r_tx;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rw     <= 1'b0;
      r_addr   <= 7'd0;
      r_tx     <= 8'h00;
      r_wr_stb <= '0;
      r_err    <= 1'b0;
    end else begin
      r_tx     <= w_tx_nxt;
      r_wr_stb <= w_wr_nxt;
      r_err    <= w_err_nxt;
      if (!spi_cs_active) begin
        r_rw   <= 1'b0;
        r_addr <= 7'd0;
      end else if (r_state == S_CMD && rx_valid) begin
        r_rw   <= rx_byte[7];
        r_addr <= rx_byte[6:0];
      end else if (r_state == S_DATA && rx_valid) begin
        r_addr <= w_addr_adv;
      end
    end
  end

  // RO entries are held at zero and collapse to constants in synthesis.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < N_REGS; i++)
        r_regs[i] <= RO_MASK[i] ? 8'h00 : RESET_VALUES[i*8 +: 8];
    end else begin
      for (int i = 0; i < N_REGS; i++)
        if (w_wr_nxt[i] && !RO_MASK[i]) r_regs[i] <= rx_byte;
    end
  end

  always_comb begin
    cfg_out = '0;
    for (int i = 0; i < N_REGS; i++)
      cfg_out[i*8 +: 8] = r_regs[i];
  end

  assign tx_byte  = r_tx;
  assign wr_stb   = r_wr_stb;
  assign xfer_err = r_err;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_regmap_ctrl.sv
// Directed bench for spi_regmap_ctrl: N_REGS=8, reg5 read-only; expectations follow REGMAP_AUTOINC_EN.
module tb_spi_regmap_ctrl;
  localparam int N = 8;
  localparam logic [N-1:0]   RO  = 8'h20;
  localparam logic [N*8-1:0] RST = {8'h77, 8'h66, 8'hEE, 8'h44, 8'h33, 8'h22, 8'h3C, 8'h11};

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cs = 1'b0;
  logic [7:0]     rxb = 8'h00;
  logic           rxv = 1'b0;
  logic [7:0]     txb;
  logic [N*8-1:0] cfg;
  logic [N-1:0]   stb;
  logic [N*8-1:0] rod = {8'hA7, 8'hA6, 8'h5A, 8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
  logic           err;
  logic           bsy;

  int n_tot = 0;
  int n_bad = 0;

  spi_regmap_ctrl #(.N_REGS(N), .RO_MASK(RO), .RESET_VALUES(RST), .ACK_BYTE(8'hFF)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .spi_cs_active(cs), .rx_byte(rxb), .rx_valid(rxv),
    .tx_byte(txb), .cfg_out(cfg), .wr_stb(stb), .ro_data(rod), .xfer_err(err), .busy(bsy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Byte presented for one cycle; on return the DUT response is visible.
  task automatic send(input logic [7:0] b);
    tick();
    rxb = b; rxv = 1'b1;
    tick();
    rxv = 1'b0;
  endtask

  task automatic gap();
    tick(); tick();
  endtask

  task automatic cs_up();
    tick(); cs = 1'b1;
    tick();
  endtask

  task automatic cs_down();
    tick(); cs = 1'b0;
    tick();
  endtask

  function automatic logic [7:0] slc(input logic [N*8-1:0] v, input int i);
    return v[i*8 +: 8];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #12;
    chk("rst_cfg1", slc(cfg, 1), 8'h3C);
    chk("rst_cfg5_ro", slc(cfg, 5), 8'h00);
    chk("rst_tx", txb, 8'h00);
    chk("rst_busy", bsy, 1'b0);
    chk("rst_stb", stb, 8'h00);
    chk("rst_err", err, 1'b0);
    tick(); rst_n = 1'b1;
    tick();

    // rx_valid in IDLE is ignored
    send(8'h81);
    chk("idle_busy", bsy, 1'b0);
    chk("idle_stb", stb, 8'h00);
    gap();

    // single write reg1 = A5
    cs_up();
    chk("w1_ack", txb, 8'hFF);
    chk("w1_busy", bsy, 1'b1);
    send(8'h81); chk("w1_status", txb, 8'h01); gap();
    send(8'h00); gap();
    send(8'hA5);
    chk("w1_stb", stb, 8'h02);
    chk("w1_cfg1", slc(cfg, 1), 8'hA5);
    chk("w1_err", err, 1'b0);
    tick();
    chk("w1_stb_off", stb, 8'h00);
    cs_down();
    chk("w1_idle", bsy, 1'b0);

    // read burst from 6
    cs_up();
    send(8'h06); chk("rb_status", txb, 8'h01); gap();
    send(8'h00); chk("rb_d0", txb, 8'h66); gap();
`ifdef REGMAP_AUTOINC_EN
    send(8'h00); chk("rb_d1", txb, 8'h77); gap();
    send(8'h00); chk("rb_d2", txb, 8'h11); gap();
    send(8'h00); chk("rb_d3", txb, 8'hA5); gap();
`else
    send(8'h00); chk("rb_d1", txb, 8'h66); gap();
    send(8'h00); chk("rb_d2", txb, 8'h66); gap();
    send(8'h00); chk("rb_d3", txb, 8'h66); gap();
`endif
    chk("rb_err", err, 1'b0);
    cs_down();

    // out-of-range read
    cs_up();
    send(8'h10); chk("oor_status", txb, 8'h00); gap();
    send(8'h00); chk("oor_turn", txb, 8'h00); chk("oor_turn_err", err, 1'b0); gap();
    send(8'h00); chk("oor_d0", txb, 8'h00); chk("oor_err0", err, 1'b1);
    tick(); chk("oor_err_off", err, 1'b0); tick();
    send(8'h00); chk("oor_err1", err, 1'b1); gap();
    cs_down();

    // write to RO reg5
    cs_up();
    send(8'h85); chk("ro_status", txb, 8'h01); gap();
    send(8'h00); gap();
    send(8'h55);
    chk("ro_stb", stb, 8'h00);
    chk("ro_err", err, 1'b1);
    chk("ro_cfg5", slc(cfg, 5), 8'h00);
    gap();
    cs_down();
    cs_up();
    send(8'h05); gap();
    send(8'h00); chk("ro_read", txb, 8'h5A); gap();
    cs_down();

    // CS drop together with write data
    cs_up();
    send(8'h82); gap();
    send(8'h00); gap();
    tick();
    rxb = 8'hCC; rxv = 1'b1; cs = 1'b0;
    tick();
    rxv = 1'b0;
    chk("drop_stb", stb, 8'h00);
    chk("drop_busy", bsy, 1'b0);
    chk("drop_cfg2", slc(cfg, 2), 8'h22);
    gap();
    cs_up();
    send(8'h83); chk("drop_next_status", txb, 8'h01); gap();
    send(8'h00); gap();
    send(8'h9D);
    chk("drop_next_stb", stb, 8'h08);
    chk("drop_next_cfg3", slc(cfg, 3), 8'h9D);
    gap();
    cs_down();

    // write burst across the wrap point
    cs_up();
    send(8'h87); gap();
    send(8'h00); gap();
    send(8'h01); chk("wb_stb0", stb, 8'h80); gap();
    send(8'h02);
`ifdef REGMAP_AUTOINC_EN
    chk("wb_stb1", stb, 8'h01);
    chk("wb_cfg7", slc(cfg, 7), 8'h01);
    chk("wb_cfg0", slc(cfg, 0), 8'h02);
`else
    chk("wb_stb1", stb, 8'h80);
    chk("wb_cfg7", slc(cfg, 7), 8'h02);
    chk("wb_cfg0", slc(cfg, 0), 8'h11);
`endif
    gap();
    cs_down();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_regmap_ctrl.md
# spi_regmap_ctrl

Parametrised SPI register-map controller: the command/address decoder and register file that sits behind the SPI byte engine. It decodes a command byte, answers with an address-valid status byte, then streams burst reads or writes over N_REGS 8-bit registers, each either read-write (driven out as configuration) or read-only (sampled from status inputs). Address auto-increment with wrap is a compile-time option.

## Interface
- N_REGS, 8: number of registers; power of two, 2..128; address width AW = clog2(N_REGS).
- RO_MASK, 0: N_REGS bits; bit i = 1 makes register i read-only.
- RESET_VALUES, 0: N_REGS*8 bits; reset value of RW register i in bits [8i+7:8i].
- ACK_BYTE, 8'hFF: byte preloaded on tx_byte at start of every transaction.

- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- spi_cs_active  in  1  high while chip-select is asserted (already synchronised to sys_clk).
- rx_byte  in  8  last byte received from the SPI engine.
- rx_valid  in  1  one-cycle pulse, rx_byte valid.
- tx_byte  out  8  byte the SPI engine shifts out in the next byte slot.
- cfg_out  out  N_REGS*8  current RW register contents (RO slices read 0).
- wr_stb  out  N_REGS  one-cycle pulse, register i written this cycle.
- ro_data  in  N_REGS*8  live values for RO registers (RW slices ignored).
- xfer_err  out  1  one-cycle pulse on out-of-range or RO-write access.
- busy  out  1  high whenever state is not IDLE.

## Operation
- Frame: byte0 = command {rw, addr[6:0]} (rw = 1 write); byte1 = turnaround; byte2.. = data.
- States: IDLE, CMD, TURN, DATA.
  - IDLE -> CMD on rising edge of spi_cs_active; tx_byte <= ACK_BYTE.
  - CMD, rx_valid: latch rw and addr; tx_byte <= {7'b0, addr < N_REGS}; -> TURN.
  - TURN, rx_valid: rx_byte discarded; on read, tx_byte <= reg[addr]; -> DATA.
  - DATA, rx_valid, write: if addr valid and RW, reg[addr] <= rx_byte and wr_stb[addr] pulses; else no change and xfer_err pulses. Then address advance (see Configuration).
  - DATA, rx_valid, read: address advance, then tx_byte <= reg[new addr]; out-of-range read returns 8'h00 and pulses xfer_err.
  - Any state: spi_cs_active low -> IDLE next cycle; latched cmd/addr discarded; registers keep contents.
- Read value of register i: RW -> stored value; RO -> ro_data slice sampled at the update edge.
- Address compare is on the full 7-bit addr; only addr < N_REGS is valid. Wrap is at N_REGS-1 -> 0 within AW bits, so an initially valid burst stays valid.
- Reset: state IDLE, tx_byte 8'h00, RW registers = RESET_VALUES, wr_stb 0, xfer_err 0, busy 0. Reset mid-burst aborts; no partial write.

## Timing
- All responses registered: rx_valid at edge t -> tx_byte, cfg_out, wr_stb, xfer_err, state valid after edge t+1.
- tx_byte stable from t+1 until next update; SPI engine needs at least 2 sys_clk between rx_valid and start of next byte slot.
- rx_valid with spi_cs_active low in the same cycle: deassertion wins, byte dropped, no write.
- rx_valid in IDLE ignored.
- wr_stb exactly one cycle per accepted data byte; back-to-back rx_valid supported (one byte per cycle).

## Configuration
- REGMAP_AUTOINC_EN defined: address increments by 1 after every DATA byte, wrapping at N_REGS-1 -> 0.
- Not defined: address fixed for the whole transaction; repeated reads return the same register, repeated writes overwrite it.

## Test plan
- Reset with RESET_VALUES reg1 = 8'h3C -> cfg_out slice 1 = 8'h3C, tx_byte 8'h00, busy 0, wr_stb 0.
- CS assert, cmd 8'h81, turn, data 8'hA5 -> tx 8'hFF, 8'h01; reg1 = 8'hA5; wr_stb[1] one cycle at t+1.
- AUTOINC, N_REGS = 8, read burst from addr 6, 4 data bytes -> tx reg6, reg7, reg0, reg1 (wrap).
- Read cmd 8'h10 with N_REGS = 8 -> status 8'h00, data 8'h00, xfer_err pulse per data byte.
- Write 8'h55 to RO reg 5 (RO_MASK bit 5) -> no wr_stb, xfer_err pulse; read back = ro_data slice 5.
- Drop CS in same cycle as a write data rx_valid -> no write, busy 0 next cycle; next frame decodes normally.
